// File: rtl/noc_pkg.sv
// Shared routing definitions for the ring router node: route classes, flit field
// offsets and the shortest-modular-distance route decision.
package noc_pkg;

  typedef enum logic [1:0] {RT_LOC, RT_CW, RT_CCW, RT_DROP} route_e;

  localparam int TYPE_BIT = 0;
  localparam int DEST_LSB = 1;

  // Distance is measured clockwise from src; an exact half-ring tie is sent clockwise.
  function automatic route_e route_calc(input int dest, input int src, input int nodes);
    int diff;
    if (dest >= nodes) return RT_DROP;
    diff = (dest >= src) ? dest - src : dest + nodes - src;
    if (diff == 0) return RT_LOC;
    if (diff <= nodes / 2) return RT_CW;
    return RT_CCW;
  endfunction

endpackage

// File: rtl/noc_ring_route_unit_if.sv
// Valid/ready flit channel used for every stream entering or leaving the route unit.
interface noc_ring_route_unit_if #(parameter int WIDTH = 11);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/rl_fifo.sv
// Valid/ready synchronous FIFO with occupancy-count full/empty; the output data
// holds the last delivered flit while the FIFO is empty.
module rl_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OCC_W-1:0] count;
  logic [WIDTH-1:0] last_q;
  logic             full, empty, push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == OCC_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;
  assign out_data  = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= nxt_ptr(wr_ptr);
      if (pop) begin
        rd_ptr <= nxt_ptr(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/noc_ring_route_unit.sv
// Ring router node routing stage: destination decode, per-output buffering with
// backpressure, illegal-destination drop counting and the arbiter return path.
module noc_ring_route_unit
  import noc_pkg::*;
#(
  parameter int WIDTH     = 11,
  parameter int ADDR_W    = 3,
  parameter int NUM_NODES = 8,
  parameter int SRC_ID    = 1,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_ring_route_unit_if.slave  in_if,
  noc_ring_route_unit_if.master loc_if,
  noc_ring_route_unit_if.master cw_if,
  noc_ring_route_unit_if.master ccw_if,
  noc_ring_route_unit_if.slave  arb_if,
  noc_ring_route_unit_if.master rl_if,
  output logic [CNT_W-1:0]     drop_cnt
);

  logic [ADDR_W-1:0] dest;
  route_e            route;
  logic              loc_free, cw_free, ccw_free;
  logic              in_ready, accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign dest  = in_if.data[DEST_LSB +: ADDR_W];
  assign route = route_calc(int'(dest), SRC_ID, NUM_NODES);

  // Readiness comes from start-of-cycle occupancy of the selected FIFO only.
  always_comb begin
    in_ready = 1'b1;
    case (route)
      RT_LOC:  in_ready = loc_free;
      RT_CW:   in_ready = cw_free;
      RT_CCW:  in_ready = ccw_free;
      default: in_ready = 1'b1;
    endcase
  end

  assign in_if.ready = in_ready;
  assign accept      = in_if.valid && in_ready;

  rl_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_loc (
    .clk(clk), .rst(rst),
    .in_valid(accept && (route == RT_LOC)), .in_ready(loc_free), .in_data(in_if.data),
    .out_valid(loc_if.valid), .out_ready(loc_if.ready), .out_data(loc_if.data)
  );

  rl_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_cw (
    .clk(clk), .rst(rst),
    .in_valid(accept && (route == RT_CW)), .in_ready(cw_free), .in_data(in_if.data),
    .out_valid(cw_if.valid), .out_ready(cw_if.ready), .out_data(cw_if.data)
  );

  rl_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ccw (
    .clk(clk), .rst(rst),
    .in_valid(accept && (route == RT_CCW)), .in_ready(ccw_free), .in_data(in_if.data),
    .out_valid(ccw_if.valid), .out_ready(ccw_if.ready), .out_data(ccw_if.data)
  );

  rl_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_arb (
    .clk(clk), .rst(rst),
    .in_valid(arb_if.valid), .in_ready(arb_if.ready), .in_data(arb_if.data),
    .out_valid(rl_if.valid), .out_ready(rl_if.ready), .out_data(rl_if.data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else if (accept && (route == RT_DROP)) drop_cnt <= sat_inc(drop_cnt);
  end

endmodule

// File: tb/tb_noc_ring_route_unit.sv
// Directed bench for noc_ring_route_unit: default node (8 nodes, id 1) plus a
// 6-node build used for illegal-destination drops.
module tb_noc_ring_route_unit;

  localparam int W = 11;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  noc_ring_route_unit_if #(.WIDTH(W)) in_if ();
  noc_ring_route_unit_if #(.WIDTH(W)) loc_if ();
  noc_ring_route_unit_if #(.WIDTH(W)) cw_if ();
  noc_ring_route_unit_if #(.WIDTH(W)) ccw_if ();
  noc_ring_route_unit_if #(.WIDTH(W)) arb_if ();
  noc_ring_route_unit_if #(.WIDTH(W)) rl_if ();
  noc_ring_route_unit_if #(.WIDTH(W)) in6 ();
  noc_ring_route_unit_if #(.WIDTH(W)) loc6 ();
  noc_ring_route_unit_if #(.WIDTH(W)) cw6 ();
  noc_ring_route_unit_if #(.WIDTH(W)) ccw6 ();
  noc_ring_route_unit_if #(.WIDTH(W)) arb6 ();
  noc_ring_route_unit_if #(.WIDTH(W)) rl6 ();

  logic [7:0] drop_cnt, drop_cnt6;

  noc_ring_route_unit dut (
    .clk(clk), .rst(rst), .in_if(in_if), .loc_if(loc_if), .cw_if(cw_if),
    .ccw_if(ccw_if), .arb_if(arb_if), .rl_if(rl_if), .drop_cnt(drop_cnt)
  );

  noc_ring_route_unit #(.NUM_NODES(6)) dut6 (
    .clk(clk), .rst(rst), .in_if(in6), .loc_if(loc6), .cw_if(cw6),
    .ccw_if(ccw6), .arb_if(arb6), .rl_if(rl6), .drop_cnt(drop_cnt6)
  );

  function automatic logic [W-1:0] mk(input int dest, input int tag);
    return {7'(tag), 3'(dest), 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_if.valid = 0; in_if.data = '0; arb_if.valid = 0; arb_if.data = '0;
    loc_if.ready = 1; cw_if.ready = 1; ccw_if.ready = 1; rl_if.ready = 1;
    in6.valid = 0; in6.data = '0; arb6.valid = 0; arb6.data = '0;
    loc6.ready = 1; cw6.ready = 1; ccw6.ready = 1; rl6.ready = 1;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if ({loc_if.valid, cw_if.valid, ccw_if.valid, rl_if.valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_valids: got %b want 0000", {loc_if.valid, cw_if.valid, ccw_if.valid, rl_if.valid}); end
    checks++; if ({loc_if.data, cw_if.data, ccw_if.data, rl_if.data} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h want 0", loc_if.data, cw_if.data, ccw_if.data, rl_if.data); end
    checks++; if (drop_cnt !== 8'd0 || drop_cnt6 !== 8'd0) begin
      errors++; $display("FAIL reset_drop_cnt: got %0d/%0d want 0/0", drop_cnt, drop_cnt6); end
    checks++; if (in_if.ready !== 1'b1 || arb_if.ready !== 1'b1) begin
      errors++; $display("FAIL reset_readies: got in=%b arb=%b want 1/1", in_if.ready, arb_if.ready); end
  endtask

  task automatic test_loc();
    in_if.valid = 1; in_if.data = mk(1, 'h11);
    #1;
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL loc_in_ready: got %b want 1", in_if.ready); end
    step();
    in_if.valid = 0;
    checks++; if (loc_if.valid !== 1'b1 || loc_if.data !== mk(1, 'h11)) begin
      errors++; $display("FAIL loc_out: got v=%b d=%h want v=1 d=%h", loc_if.valid, loc_if.data, mk(1, 'h11)); end
    checks++; if ({cw_if.valid, ccw_if.valid} !== 2'b00) begin
      errors++; $display("FAIL loc_others_idle: got %b want 00", {cw_if.valid, ccw_if.valid}); end
    step();
    checks++; if (loc_if.valid !== 1'b0 || loc_if.data !== mk(1, 'h11)) begin
      errors++; $display("FAIL loc_empty_hold: got v=%b d=%h want v=0 d=%h", loc_if.valid, loc_if.data, mk(1, 'h11)); end
  endtask

  task automatic test_route();
    int         dests [6] = '{3, 5, 0, 2, 6, 7};
    logic [2:0] exp_v [6] = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b001, 3'b001};
    logic [W-1:0] got;
    for (int i = 0; i < 6; i++) begin
      in_if.valid = 1; in_if.data = mk(dests[i], 'h20 + i);
      step();
      in_if.valid = 0;
      checks++; if ({loc_if.valid, cw_if.valid, ccw_if.valid} !== exp_v[i]) begin
        errors++; $display("FAIL route_dest%0d: got %b want %b", dests[i], {loc_if.valid, cw_if.valid, ccw_if.valid}, exp_v[i]); end
      got = (exp_v[i] == 3'b010) ? cw_if.data : ccw_if.data;
      checks++; if (got !== mk(dests[i], 'h20 + i)) begin
        errors++; $display("FAIL route_data%0d: got %h want %h", dests[i], got, mk(dests[i], 'h20 + i)); end
      step();
    end
  endtask

  task automatic test_drop();
    int         dests [3] = '{4, 5, 0};
    logic [2:0] exp_v [3] = '{3'b010, 3'b001, 3'b001};
    in6.valid = 1; in6.data = mk(7, 1);
    #1;
    checks++; if (in6.ready !== 1'b1) begin errors++; $display("FAIL drop_in_ready: got %b want 1", in6.ready); end
    step();
    checks++; if (drop_cnt6 !== 8'd1) begin errors++; $display("FAIL drop_first: got %0d want 1", drop_cnt6); end
    checks++; if ({loc6.valid, cw6.valid, ccw6.valid} !== 3'b000) begin
      errors++; $display("FAIL drop_not_forwarded: got %b want 000", {loc6.valid, cw6.valid, ccw6.valid}); end
    repeat (253) step();
    checks++; if (drop_cnt6 !== 8'd254) begin errors++; $display("FAIL drop_254: got %0d want 254", drop_cnt6); end
    in6.data = mk(6, 2);
    step();
    checks++; if (drop_cnt6 !== 8'd255) begin errors++; $display("FAIL drop_255: got %0d want 255", drop_cnt6); end
    step();
    in6.valid = 0;
    checks++; if (drop_cnt6 !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt6); end
    for (int i = 0; i < 3; i++) begin
      in6.valid = 1; in6.data = mk(dests[i], 'h30 + i);
      step();
      in6.valid = 0;
      checks++; if ({loc6.valid, cw6.valid, ccw6.valid} !== exp_v[i]) begin
        errors++; $display("FAIL route6_dest%0d: got %b want %b", dests[i], {loc6.valid, cw6.valid, ccw6.valid}, exp_v[i]); end
      step();
    end
  endtask

  task automatic test_hol();
    cw_if.ready = 0;
    in_if.valid = 1; in_if.data = mk(3, 'h31);
    step();
    in_if.data = mk(3, 'h32);
    step();
    in_if.data = mk(3, 'h33);
    #1;
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL hol_full_ready: got %b want 0", in_if.ready); end
    checks++; if (cw_if.valid !== 1'b1 || cw_if.data !== mk(3, 'h31)) begin
      errors++; $display("FAIL hol_head_a: got v=%b d=%h want v=1 d=%h", cw_if.valid, cw_if.data, mk(3, 'h31)); end
    step();
    checks++; if (cw_if.data !== mk(3, 'h31) || in_if.ready !== 1'b0 || loc_if.valid !== 1'b0) begin
      errors++; $display("FAIL hol_stall: got d=%h rdy=%b loc=%b want d=%h rdy=0 loc=0", cw_if.data, in_if.ready, loc_if.valid, mk(3, 'h31)); end
    cw_if.ready = 1;
    step();
    checks++; if (cw_if.data !== mk(3, 'h32) || in_if.ready !== 1'b1) begin
      errors++; $display("FAIL hol_out_b: got d=%h rdy=%b want d=%h rdy=1", cw_if.data, in_if.ready, mk(3, 'h32)); end
    step();
    checks++; if (cw_if.valid !== 1'b1 || cw_if.data !== mk(3, 'h33)) begin
      errors++; $display("FAIL hol_out_c: got v=%b d=%h want v=1 d=%h", cw_if.valid, cw_if.data, mk(3, 'h33)); end
    in_if.data = mk(1, 'h35);
    step();
    in_if.valid = 0;
    checks++; if (cw_if.valid !== 1'b0 || loc_if.valid !== 1'b1 || loc_if.data !== mk(1, 'h35)) begin
      errors++; $display("FAIL hol_loc_after: got cw=%b loc=%b d=%h want cw=0 loc=1 d=%h", cw_if.valid, loc_if.valid, loc_if.data, mk(1, 'h35)); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      in_if.valid = 1; in_if.data = mk(3 + (i % 2), 'h40 + i);
      #1;
      checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_if.ready); end
      step();
      checks++; if (cw_if.valid !== 1'b1 || cw_if.data !== mk(3 + (i % 2), 'h40 + i)) begin
        errors++; $display("FAIL b2b_out%0d: got v=%b d=%h want v=1 d=%h", i, cw_if.valid, cw_if.data, mk(3 + (i % 2), 'h40 + i)); end
    end
    in_if.valid = 0;
    step();
    checks++; if (cw_if.valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", cw_if.valid); end
  endtask

  task automatic test_return();
    logic [W-1:0] sb [$];
    logic [W-1:0] nxt = 11'h200;
    int sent = 0, rcvd = 0;
    rl_if.ready = 1; arb_if.valid = 1;
    for (int i = 0; i < 6; i++) begin
      arb_if.data = 11'h100 + 11'(i);
      #1;
      checks++; if (arb_if.ready !== 1'b1) begin errors++; $display("FAIL ret_stream_ready%0d: got %b want 1", i, arb_if.ready); end
      step();
      checks++; if (rl_if.valid !== 1'b1 || rl_if.data !== 11'h100 + 11'(i)) begin
        errors++; $display("FAIL ret_stream%0d: got v=%b d=%h want v=1 d=%h", i, rl_if.valid, rl_if.data, 11'h100 + 11'(i)); end
    end
    arb_if.valid = 0;
    step();
    checks++; if (rl_if.valid !== 1'b0) begin errors++; $display("FAIL ret_stream_end: got %b want 0", rl_if.valid); end
    for (int c = 0; c < 30; c++) begin
      rl_if.ready  = (c >= 24) || ((c % 3) != 0);
      arb_if.valid = (c < 20) && ((c % 5) != 4);
      arb_if.data  = nxt;
      #1;
      if (rl_if.valid && rl_if.ready) begin
        rcvd++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL ret_order: got %h want nothing", rl_if.data);
        end else begin
          if (rl_if.data !== sb[0]) begin errors++; $display("FAIL ret_order: got %h want %h", rl_if.data, sb[0]); end
          void'(sb.pop_front());
        end
      end
      if (arb_if.valid && arb_if.ready) begin
        sb.push_back(nxt); nxt = nxt + 1'b1; sent++;
      end
      step();
    end
    arb_if.valid = 0; rl_if.ready = 1;
    checks++; if (rcvd !== sent || sent < 10) begin
      errors++; $display("FAIL ret_count: got rcvd=%0d sent=%0d want equal and >=10", rcvd, sent); end
  endtask

  task automatic test_reset_full();
    loc_if.ready = 0; cw_if.ready = 0; ccw_if.ready = 0; rl_if.ready = 0;
    arb_if.valid = 1; arb_if.data = 11'h301;
    in_if.valid = 1; in_if.data = mk(1, 'h51);
    step();
    arb_if.data = 11'h302; in_if.data = mk(1, 'h52);
    step();
    arb_if.valid = 0;
    in_if.data = mk(3, 'h53); step();
    in_if.data = mk(3, 'h54); step();
    in_if.data = mk(0, 'h55); step();
    in_if.data = mk(0, 'h56); step();
    in_if.data = mk(1, 'h57);
    #1;
    checks++; if ({in_if.ready, arb_if.ready} !== 2'b00) begin
      errors++; $display("FAIL full_readies: got %b want 00", {in_if.ready, arb_if.ready}); end
    checks++; if ({loc_if.valid, cw_if.valid, ccw_if.valid, rl_if.valid} !== 4'b1111) begin
      errors++; $display("FAIL full_valids: got %b want 1111", {loc_if.valid, cw_if.valid, ccw_if.valid, rl_if.valid}); end
    in_if.valid = 0;
    rst = 1;
    #1;
    checks++; if ({loc_if.valid, cw_if.valid, ccw_if.valid, rl_if.valid} !== 4'b0000) begin
      errors++; $display("FAIL rst_full_valids: got %b want 0000", {loc_if.valid, cw_if.valid, ccw_if.valid, rl_if.valid}); end
    checks++; if ({loc_if.data, cw_if.data, ccw_if.data, rl_if.data} !== '0) begin
      errors++; $display("FAIL rst_full_data: got %h %h %h %h want 0", loc_if.data, cw_if.data, ccw_if.data, rl_if.data); end
    checks++; if (drop_cnt6 !== 8'd0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_full_drop: got %0d/%0d want 0/0", drop_cnt6, drop_cnt); end
    checks++; if ({in_if.ready, arb_if.ready} !== 2'b11) begin
      errors++; $display("FAIL rst_full_readies: got %b want 11", {in_if.ready, arb_if.ready}); end
    loc_if.ready = 1; cw_if.ready = 1; ccw_if.ready = 1; rl_if.ready = 1;
    step();
    rst = 0;
    in_if.valid = 1; in_if.data = mk(0, 'h60);
    step();
    in_if.valid = 0;
    checks++; if ({loc_if.valid, cw_if.valid, ccw_if.valid} !== 3'b001 || ccw_if.data !== mk(0, 'h60)) begin
      errors++; $display("FAIL post_rst_route: got v=%b d=%h want v=001 d=%h", {loc_if.valid, cw_if.valid, ccw_if.valid}, ccw_if.data, mk(0, 'h60)); end
    step();
  endtask

  initial begin
    test_reset();
    test_loc();
    test_route();
    test_drop();
    test_hol();
    test_back_to_back();
    test_return();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
